// File: rtl/dsp_lane_arbiter.sv
// Purpose : round-robin burst arbiter sharing NUM_LANES DSP multiplier lanes between
//           NUM_REQ requesters; muxes operands to the DSPs and tags returning products.
// Latency : grant 1 cycle after req is seen in IDLE; operands pass to dsp_a/dsp_b
//           combinationally; products return DSP_LAT cycles after the accepting beat.
// Backpressure: op_ready only for the granted requester during BURST; stalls via
//           op_valid=0 are unbounded; results have no backpressure (owner must sink).
// Ports   : clk/rst (async, active-high); req/req_len burst request per requester;
//           gnt one-hot ownership; op_valid/op_ready/op_a/op_b operand beats;
//           res_valid/res_last/res_data returned products; dsp_a/dsp_b/dsp_ce/dsp_out
//           DSP wrapper side; busy = not IDLE.
module dsp_lane_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_LANES = 5,
  parameter int A_W       = 18,
  parameter int B_W       = 18,
  parameter int P_W       = 37,
  parameter int DSP_LAT   = 1,
  parameter int BURST_W   = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BURST_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic [NUM_REQ-1:0]             op_valid,
  output logic [NUM_REQ-1:0]             op_ready,
  input  logic [NUM_REQ*NUM_LANES*A_W-1:0] op_a,
  input  logic [NUM_REQ*NUM_LANES*B_W-1:0] op_b,
  output logic [NUM_REQ-1:0]             res_valid,
  output logic                           res_last,
  output logic [NUM_LANES*P_W-1:0]       res_data,
  output logic [NUM_LANES*A_W-1:0]       dsp_a,
  output logic [NUM_LANES*B_W-1:0]       dsp_b,
  output logic                           dsp_ce,
  input  logic [NUM_LANES*P_W-1:0]       dsp_out,
  output logic                           busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [DSP_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [DSP_LAT-1:0]   tag_last_q, tag_last_d;

  logic                 accept;
  logic                 found;
  logic [ID_W-1:0]      win;
  logic [BURST_W-1:0]   win_len;
  int                   idx;

  // gnt_q stays set through DRAIN, so it doubles as the owner mask for op_ready
  // and for routing returning products.
  assign op_ready = (state_q == BURST) ? gnt_q : '0;
  assign accept   = |(op_valid & op_ready);
  assign dsp_ce   = accept;
  assign dsp_a    = accept ? op_a[int'(id_q)*NUM_LANES*A_W +: NUM_LANES*A_W] : '0;
  assign dsp_b    = accept ? op_b[int'(id_q)*NUM_LANES*B_W +: NUM_LANES*B_W] : '0;

  assign res_valid = tag_vld_q[DSP_LAT-1] ? gnt_q : '0;
  assign res_last  = tag_vld_q[DSP_LAT-1] & tag_last_q[DSP_LAT-1];
  assign res_data  = dsp_out;

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    win_len = req_len[int'(win)*BURST_W +: BURST_W];
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;

    // Tag pipeline shifts every cycle; stage 0 captures the beat issued now.
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = accept;
    tag_last_d[0] = accept && (cnt_q == BURST_W'(1));
    for (int k = 1; k < DSP_LAT; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1];
      tag_last_d[k] = tag_last_q[k-1];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          id_d    = win;
          gnt_d   = NUM_REQ'(1) << win;
          cnt_d   = (win_len == '0) ? BURST_W'(1) : win_len;
        end
      end
      BURST: begin
        if (accept) begin
          if (cnt_q != '0) cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the last tagged product has been presented this cycle.
        if (tag_vld_d == '0) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
    end
  end

endmodule

// File: tb/tb_dsp_lane_arbiter.sv
// Purpose : self-checking bench for dsp_lane_arbiter with a transaction-level reference
//           model (owner, beats left, timestamped result queue) and a behavioural DSP.
// Latency : checks every cycle one time unit after the falling edge.
// Backpressure: op_valid driven always-on, patterned or random per phase.
module tb_dsp_lane_arbiter;

  localparam int NR  = 2;
  localparam int NL  = 5;
  localparam int AW  = 18;
  localparam int BW  = 18;
  localparam int PW  = 37;
  localparam int LAT = 3;
  localparam int LW  = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req;
  logic [NR*LW-1:0]     req_len;
  logic [NR-1:0]        gnt;
  logic [NR-1:0]        op_valid;
  logic [NR-1:0]        op_ready;
  logic [NR*NL*AW-1:0]  op_a;
  logic [NR*NL*BW-1:0]  op_b;
  logic [NR-1:0]        res_valid;
  logic                 res_last;
  logic [NL*PW-1:0]     res_data;
  logic [NL*AW-1:0]     dsp_a;
  logic [NL*BW-1:0]     dsp_b;
  logic                 dsp_ce;
  logic [NL*PW-1:0]     dsp_out;
  logic                 busy;

  dsp_lane_arbiter #(
    .NUM_REQ(NR), .NUM_LANES(NL), .A_W(AW), .B_W(BW), .P_W(PW), .DSP_LAT(LAT), .BURST_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_last(res_last), .res_data(res_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce), .dsp_out(dsp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NL*PW-1:0] mult(input logic [NL*AW-1:0] a, input logic [NL*BW-1:0] b);
    logic [NL*PW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) r[l*PW +: PW] = PW'(a[l*AW +: AW]) * PW'(b[l*BW +: BW]);
    return r;
  endfunction

  // Behavioural DSP: free-running LAT-stage multiply pipeline.
  logic [NL*PW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mult(dsp_a, dsp_b);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dsp_out = pipe[LAT-1];

  typedef struct {
    int               due;
    int               owner;
    bit               last;
    logic [NL*PW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: who owns the lanes, beats still owed, when the drain ends.
  int m_owner = -1;
  int m_left  = 0;
  int m_rr    = 0;
  int m_drain_end = 0;

  // Stimulus controls.
  logic [NR-1:0] req_drv = '0;
  int            len_drv [NR];
  int            vmode = 0;
  int            pat_k = 0;
  bit            dir   = 1'b0;
  int            dir_val = 1;
  bit            rnd_req = 1'b0;
  logic [3:0]    pat;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    if (rnd_req) begin
      req_drv = NR'($urandom_range(0, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) len_drv[r] = $urandom_range(0, 7);
    end
    req = req_drv;
    for (int r = 0; r < NR; r++) req_len[r*LW +: LW] = LW'(len_drv[r]);
    case (vmode)
      0: op_valid = '1;
      1: op_valid = NR'($urandom_range(0, (1 << NR) - 1));
      default: begin
        op_valid = {NR{pat[pat_k % 4]}};
        pat_k++;
      end
    endcase
    for (int l = 0; l < NR*NL; l++) begin
      op_a[l*AW +: AW] = dir ? AW'(dir_val) : AW'($urandom_range(0, (1 << AW) - 1));
      op_b[l*BW +: BW] = dir ? BW'(dir_val) : BW'($urandom_range(0, (1 << BW) - 1));
    end
  endtask

  task automatic check_and_model();
    logic [NR-1:0]    e_gnt, e_rdy, e_rv;
    logic [NL*AW-1:0] e_a;
    logic [NL*BW-1:0] e_b;
    bit               acc, e_last;
    logic [NL*PW-1:0] e_data;
    exp_t             t;

    e_gnt = (m_owner >= 0) ? NR'(1) << m_owner : '0;
    e_rdy = (m_owner >= 0 && m_left > 0) ? e_gnt : '0;
    acc   = (m_owner >= 0 && m_left > 0 && op_valid[m_owner]);
    e_a   = acc ? op_a[m_owner*NL*AW +: NL*AW] : '0;
    e_b   = acc ? op_b[m_owner*NL*BW +: NL*BW] : '0;

    chk("gnt", gnt, e_gnt);
    chk("busy", busy, m_owner >= 0);
    chk("op_ready", op_ready, e_rdy);
    chk("dsp_ce", dsp_ce, acc);
    chk("dsp_a", dsp_a, e_a);
    chk("dsp_b", dsp_b, e_b);

    e_rv = '0; e_last = 1'b0; e_data = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      t = exp_q.pop_front();
      e_rv = NR'(1) << t.owner;
      e_last = t.last;
      e_data = t.data;
    end
    chk("res_valid", res_valid, e_rv);
    chk("res_last", res_last, e_last);
    if (e_rv != '0) chk("res_data", res_data, e_data);

    // Advance the model to the next cycle.
    if (m_owner < 0) begin
      if (req_drv != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (req_drv[(m_rr + i) % NR]) begin
            m_owner = (m_rr + i) % NR;
            break;
          end
        end
        m_left = (len_drv[m_owner] == 0) ? 1 : len_drv[m_owner];
      end
    end else if (m_left > 0) begin
      if (acc) begin
        t.due   = cyc + LAT;
        t.owner = m_owner;
        t.last  = (m_left == 1);
        t.data  = mult(e_a, e_b);
        exp_q.push_back(t);
        m_left--;
        if (dir) dir_val++;
        if (m_left == 0) m_drain_end = cyc + LAT;
      end
    end else if (cyc == m_drain_end) begin
      m_rr = (m_owner + 1) % NR;
      m_owner = -1;
    end
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      drive();
      #1;
      check_and_model();
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_op_ready"}, op_ready, '0);
    chk({tag, "_dsp_ce"}, dsp_ce, '0);
    chk({tag, "_dsp_a"}, dsp_a, '0);
    chk({tag, "_dsp_b"}, dsp_b, '0);
    chk({tag, "_res_valid"}, res_valid, '0);
    chk({tag, "_res_last"}, res_last, '0);
  endtask

  initial begin
    bit reached;
    pat = 4'b1001;
    for (int r = 0; r < NR; r++) len_drv[r] = 0;
    rst = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single burst: requester 0, 3 beats, lane operands 1,2,3.
    dir = 1'b1; dir_val = 1;
    req_drv = 2'b01; len_drv[0] = 3;
    step(2);
    req_drv = '0;
    step(12);
    dir = 1'b0;

    // Round-robin: both requesting, 2 beats each.
    req_drv = 2'b11; len_drv[0] = 2; len_drv[1] = 2;
    step(40);
    req_drv = '0;
    step(10);

    // Stall pattern 1,0,0,1 on op_valid.
    vmode = 2; pat_k = 0;
    req_drv = 2'b01; len_drv[0] = 4;
    step(2);
    req_drv = '0;
    step(20);
    vmode = 0;

    // len=0 gives one beat.
    req_drv = 2'b10; len_drv[1] = 0;
    step(1);
    req_drv = '0;
    step(10);

    // Request dropped mid-burst of 4 with random valid.
    vmode = 1;
    req_drv = 2'b01; len_drv[0] = 4;
    step(3);
    req_drv = '0;
    step(25);

    // Random traffic.
    rnd_req = 1'b1;
    step(400);
    rnd_req = 1'b0;
    req_drv = '0;
    step(80);

    // Reset after 2 of 5 beats from requester 0.
    vmode = 0;
    req_drv = 2'b01; len_drv[0] = 5;
    reached = 1'b0;
    for (int n = 0; n < 60 && !reached; n++) begin
      if (m_owner == 0 && m_left == 3) reached = 1'b1;
      else step(1);
    end
    chk("rst_wait", reached, 1'b1);
    drive();
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    m_owner = -1; m_left = 0; m_rr = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    req_drv = 2'b11; len_drv[0] = 2; len_drv[1] = 2;
    step(1);
    chk("post_rst_owner", m_owner, 0);
    step(20);
    req_drv = '0;
    step(20);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("final_busy", busy, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
